// File: rtl/read_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : read_arbiter
//  Purpose  : Read-side crossbar arbiter. Round-robins AR among masters and R
//             among slaves, and keeps a per-slave in-order master record so
//             returning bursts are routed to the requester.
//  Revision : 1.0
// ============================================================================
module read_arbiter #(
    parameter int M          = 2,
    parameter int S          = 2,
    parameter int ADDR_WIDTH = 32,
    parameter int DEPTH      = 4
) (
    input  logic                      clk,
    input  logic                      clr,
    input  logic [M-1:0]              AR_valid_f,
    input  logic [M*ADDR_WIDTH-1:0]   AR_addr_f,
    input  logic [S-1:0]              AR_ready_f,
    output logic [M-1:0]              AR_grant_f,
    output logic [M*$clog2(S)-1:0]    AR_sel_f,
    input  logic [S-1:0]              R_valid_f,
    input  logic [S-1:0]              R_last_f,
    input  logic [M-1:0]              R_ready_f,
    output logic [S-1:0]              R_grant_s_f,
    output logic [M-1:0]              R_grant_m_f,
    output logic [M*$clog2(S)-1:0]    R_sel_m_f,
    output logic                      R_err
);

    localparam int MW = $clog2(M);
    localparam int SW = $clog2(S);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [0:0] AR_IDLE  = 1'b0;
    localparam logic [0:0] AR_ALLOW = 1'b1;
    localparam logic [0:0] R_IDLE   = 1'b0;
    localparam logic [0:0] R_ALLOW  = 1'b1;

    logic [0:0]    r_ar_state;
    logic [MW-1:0] r_ar_ptr;
    logic [SW-1:0] r_ar_tgt;
    logic [0:0]    r_r_state;
    logic [SW-1:0] r_r_ptr;
    logic [MW-1:0] r_r_mst;
    logic          r_err;

    logic [SW-1:0] w_sel        [M];
    logic [MW-1:0] w_fifo_head  [S];
    logic [CW-1:0] w_fifo_cnt   [S];
    logic [S-1:0]  w_fifo_full;
    logic [S-1:0]  w_fifo_empty;

    logic          w_push;
    logic          w_pop;
    logic [SW-1:0] w_ar_sel_cur;
    logic          w_ar_valid_cur;
    logic          w_r_valid_cur;
    logic          w_r_empty_cur;
    logic [MW-1:0] w_r_head_cur;
    logic          w_unused_addr;

    // Only the slice-select bits of each address matter here.
    assign w_unused_addr = ^AR_addr_f;

    genvar gm;
    generate
        for (gm = 0; gm < M; gm++) begin : g_mst
            assign w_sel[gm] = AR_addr_f[gm*ADDR_WIDTH + 16 +: SW];
            assign AR_sel_f[gm*SW +: SW] = w_sel[gm];
            assign R_sel_m_f[gm*SW +: SW] =
                ((r_r_state == R_ALLOW) && (r_r_mst == MW'(gm))) ? r_r_ptr : '0;
        end
    endgenerate

    assign w_ar_sel_cur   = w_sel[r_ar_ptr];
    assign w_ar_valid_cur = AR_valid_f[r_ar_ptr];
    assign w_push = (r_ar_state == AR_IDLE) && w_ar_valid_cur && !w_fifo_full[w_ar_sel_cur];

    assign w_r_valid_cur = R_valid_f[r_r_ptr];
    assign w_r_empty_cur = w_fifo_empty[r_r_ptr];
    assign w_r_head_cur  = w_fifo_head[r_r_ptr];
    assign w_pop = (r_r_state == R_ALLOW) && R_valid_f[r_r_ptr]
                   && R_ready_f[r_r_mst] && R_last_f[r_r_ptr];

    genvar gs;
    generate
        for (gs = 0; gs < S; gs++) begin : g_fifo
            logic [MW-1:0] r_mem [DEPTH];
            logic [PW-1:0] r_wr;
            logic [PW-1:0] r_rd;
            logic [CW-1:0] r_cnt;
            logic          w_wr;
            logic          w_rd;

            assign w_wr = w_push && (w_ar_sel_cur == SW'(gs));
            assign w_rd = w_pop && (r_r_ptr == SW'(gs));

            always_ff @(posedge clk or negedge clr) begin
                if (!clr) begin
                    r_wr  <= '0;
                    r_rd  <= '0;
                    r_cnt <= '0;
                end else begin
                    if (w_wr)
                        r_wr <= (r_wr == PW'(DEPTH - 1)) ? '0 : r_wr + 1'b1;
                    if (w_rd)
                        r_rd <= (r_rd == PW'(DEPTH - 1)) ? '0 : r_rd + 1'b1;
                    if (w_wr && !w_rd)
                        r_cnt <= r_cnt + 1'b1;
                    else if (w_rd && !w_wr)
                        r_cnt <= r_cnt - 1'b1;
                end
            end

            // Storage needs no reset: validity is tracked by r_cnt alone.
            always_ff @(posedge clk) begin
                if (w_wr)
                    r_mem[r_wr] <= r_ar_ptr;
            end

            assign w_fifo_head[gs]  = r_mem[r_rd];
            assign w_fifo_cnt[gs]   = r_cnt;
            assign w_fifo_full[gs]  = (r_cnt == CW'(DEPTH));
            assign w_fifo_empty[gs] = (r_cnt == '0);
        end
    endgenerate

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_ar_state <= AR_IDLE;
            r_ar_ptr   <= '0;
            r_ar_tgt   <= '0;
        end else begin
            case (r_ar_state)
                AR_IDLE: begin
                    if (w_push) begin
                        r_ar_state <= AR_ALLOW;
                        r_ar_tgt   <= w_ar_sel_cur;
                    end else begin
                        r_ar_ptr <= r_ar_ptr + 1'b1;
                    end
                end
                AR_ALLOW: begin
                    // Leave on handshake, or if the master withdrew its request.
                    if (!w_ar_valid_cur || AR_ready_f[r_ar_tgt]) begin
                        r_ar_state <= AR_IDLE;
                        r_ar_ptr   <= r_ar_ptr + 1'b1;
                    end
                end
                default: r_ar_state <= AR_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_r_state <= R_IDLE;
            r_r_ptr   <= '0;
            r_r_mst   <= '0;
            r_err     <= 1'b0;
        end else begin
            r_err <= 1'b0;
            case (r_r_state)
                R_IDLE: begin
                    if (w_r_valid_cur && !w_r_empty_cur) begin
                        r_r_mst   <= w_r_head_cur;
                        r_r_state <= R_ALLOW;
                    end else begin
                        r_r_ptr <= r_r_ptr + 1'b1;
                        r_err   <= w_r_valid_cur;
                    end
                end
                R_ALLOW: begin
                    if (w_pop) begin
                        r_r_state <= R_IDLE;
                        r_r_ptr   <= r_r_ptr + 1'b1;
                    end
                end
                default: r_r_state <= R_IDLE;
            endcase
        end
    end

    assign AR_grant_f  = (r_ar_state == AR_ALLOW) ? (M'(1) << r_ar_ptr) : '0;
    assign R_grant_s_f = (r_r_state == R_ALLOW) ? (S'(1) << r_r_ptr) : '0;
    assign R_grant_m_f = (r_r_state == R_ALLOW) ? (M'(1) << r_r_mst) : '0;
    assign R_err       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_read_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_read_arbiter
//  Purpose  : Directed self-checking bench for read_arbiter (M=2, S=2).
//  Revision : 1.0
// ============================================================================
module tb_read_arbiter;

    localparam int M     = 2;
    localparam int S     = 2;
    localparam int AW    = 32;
    localparam int DEPTH = 4;

    logic          clk;
    logic          clr;
    logic [M-1:0]  AR_valid_f;
    logic [M*AW-1:0] AR_addr_f;
    logic [S-1:0]  AR_ready_f;
    logic [M-1:0]  AR_grant_f;
    logic [M-1:0]  AR_sel_f;
    logic [S-1:0]  R_valid_f;
    logic [S-1:0]  R_last_f;
    logic [M-1:0]  R_ready_f;
    logic [S-1:0]  R_grant_s_f;
    logic [M-1:0]  R_grant_m_f;
    logic [M-1:0]  R_sel_m_f;
    logic          R_err;

    int n_cmp;
    int n_err;

    logic [2:0] cnt0;
    logic [2:0] cnt1;
    assign cnt0 = dut.w_fifo_cnt[0];
    assign cnt1 = dut.w_fifo_cnt[1];

    read_arbiter #(.M(M), .S(S), .ADDR_WIDTH(AW), .DEPTH(DEPTH)) dut (
        .clk(clk), .clr(clr),
        .AR_valid_f(AR_valid_f), .AR_addr_f(AR_addr_f), .AR_ready_f(AR_ready_f),
        .AR_grant_f(AR_grant_f), .AR_sel_f(AR_sel_f),
        .R_valid_f(R_valid_f), .R_last_f(R_last_f), .R_ready_f(R_ready_f),
        .R_grant_s_f(R_grant_s_f), .R_grant_m_f(R_grant_m_f), .R_sel_m_f(R_sel_m_f),
        .R_err(R_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic do_reset();
        clr = 1'b0;
        AR_valid_f = '0; AR_addr_f = '0; AR_ready_f = '0;
        R_valid_f = '0; R_last_f = '0; R_ready_f = '0;
        repeat (2) @(negedge clk);
        clr = 1'b1;
    endtask

    task automatic issue_ar(input int m, input logic [31:0] addr);
        AR_addr_f[m*AW +: AW] = addr;
        AR_valid_f[m] = 1'b1;
        AR_ready_f = '1;
        for (int i = 0; i < 4 && AR_grant_f[m] !== 1'b1; i++) @(negedge clk);
        n_cmp++;
        if (AR_grant_f !== (2'b01 << m)) begin
            $display("FAIL ar_issue_m%0d: grant=%b want=%b", m, AR_grant_f, 2'b01 << m);
            n_err++;
        end
        @(negedge clk);
        AR_valid_f[m] = 1'b0;
    endtask

    task automatic test_reset();
        clr = 1'b0;
        AR_valid_f = '1; AR_ready_f = '1; R_valid_f = '1; R_last_f = '1; R_ready_f = '1;
        AR_addr_f = {32'h0000_0000, 32'h0001_0000};
        repeat (2) @(negedge clk);
        #1;
        n_cmp += 8;
        if (AR_grant_f !== 2'b00)  begin $display("FAIL rst_ar_grant: got=%b want=00", AR_grant_f); n_err++; end
        if (R_grant_s_f !== 2'b00) begin $display("FAIL rst_r_grant_s: got=%b want=00", R_grant_s_f); n_err++; end
        if (R_grant_m_f !== 2'b00) begin $display("FAIL rst_r_grant_m: got=%b want=00", R_grant_m_f); n_err++; end
        if (R_sel_m_f !== 2'b00)   begin $display("FAIL rst_r_sel_m: got=%b want=00", R_sel_m_f); n_err++; end
        if (R_err !== 1'b0)        begin $display("FAIL rst_r_err: got=%b want=0", R_err); n_err++; end
        if (AR_sel_f !== 2'b01)    begin $display("FAIL decode_a: got=%b want=01", AR_sel_f); n_err++; end
        if (cnt0 !== 3'd0)         begin $display("FAIL rst_cnt0: got=%0d want=0", cnt0); n_err++; end
        if (cnt1 !== 3'd0)         begin $display("FAIL rst_cnt1: got=%0d want=0", cnt1); n_err++; end
        AR_addr_f = {32'h0001_0000, 32'h0000_0000};
        #1;
        n_cmp++;
        if (AR_sel_f !== 2'b10)    begin $display("FAIL decode_b: got=%b want=10", AR_sel_f); n_err++; end
    endtask

    task automatic test_single();
        do_reset();
        AR_addr_f[31:0] = 32'h0001_0000;
        AR_valid_f = 2'b01;
        AR_ready_f = 2'b10;
        @(negedge clk);
        n_cmp += 2;
        if (AR_grant_f !== 2'b01) begin $display("FAIL single_ar_grant: got=%b want=01", AR_grant_f); n_err++; end
        if (cnt1 !== 3'd1)        begin $display("FAIL single_push: cnt1=%0d want=1", cnt1); n_err++; end
        @(negedge clk);
        n_cmp++;
        if (AR_grant_f !== 2'b00) begin $display("FAIL single_ar_drop: got=%b want=00", AR_grant_f); n_err++; end
        AR_valid_f = 2'b00;
        R_valid_f = 2'b10;
        R_ready_f = 2'b01;
        for (int i = 0; i < 4 && R_grant_s_f === 2'b00; i++) @(negedge clk);
        n_cmp++;
        if (R_grant_s_f !== 2'b10) begin $display("FAIL single_r_grant_s: got=%b want=10", R_grant_s_f); n_err++; end
        for (int b = 1; b <= 4; b++) begin
            n_cmp += 2;
            if (R_grant_m_f !== 2'b01) begin $display("FAIL single_beat%0d_grant_m: got=%b want=01", b, R_grant_m_f); n_err++; end
            if (R_sel_m_f !== 2'b01)   begin $display("FAIL single_beat%0d_sel_m: got=%b want=01", b, R_sel_m_f); n_err++; end
            R_last_f[1] = (b == 4);
            @(negedge clk);
        end
        R_valid_f = '0; R_last_f = '0;
        n_cmp += 4;
        if (R_grant_m_f !== 2'b00) begin $display("FAIL single_end_grant_m: got=%b want=00", R_grant_m_f); n_err++; end
        if (R_grant_s_f !== 2'b00) begin $display("FAIL single_end_grant_s: got=%b want=00", R_grant_s_f); n_err++; end
        if (cnt1 !== 3'd0)         begin $display("FAIL single_pop: cnt1=%0d want=0", cnt1); n_err++; end
        if (R_err !== 1'b0)        begin $display("FAIL single_r_err: got=%b want=0", R_err); n_err++; end
    endtask

    task automatic test_contention();
        logic [1:0] exp_ar [5] = '{2'b01, 2'b00, 2'b10, 2'b00, 2'b01};
        logic [1:0] exp_r  [3] = '{2'b01, 2'b10, 2'b01};
        do_reset();
        AR_valid_f = 2'b11;
        AR_ready_f = 2'b01;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_cmp++;
            if (AR_grant_f !== exp_ar[i]) begin
                $display("FAIL cont_ar_cycle%0d: got=%b want=%b", i + 1, AR_grant_f, exp_ar[i]); n_err++;
            end
        end
        AR_valid_f = 2'b01;
        @(negedge clk);
        AR_valid_f = 2'b00;
        n_cmp++;
        if (cnt0 !== 3'd3) begin $display("FAIL cont_cnt0: got=%0d want=3", cnt0); n_err++; end
        R_valid_f = 2'b01; R_last_f = 2'b01; R_ready_f = 2'b11;
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 4 && R_grant_s_f === 2'b00; i++) @(negedge clk);
            n_cmp += 2;
            if (R_grant_s_f !== 2'b01)    begin $display("FAIL cont_r%0d_grant_s: got=%b want=01", k, R_grant_s_f); n_err++; end
            if (R_grant_m_f !== exp_r[k]) begin $display("FAIL cont_r%0d_grant_m: got=%b want=%b", k, R_grant_m_f, exp_r[k]); n_err++; end
            @(negedge clk);
        end
        R_valid_f = '0; R_last_f = '0;
        n_cmp++;
        if (cnt0 !== 3'd0) begin $display("FAIL cont_drain: cnt0=%0d want=0", cnt0); n_err++; end
    endtask

    task automatic test_fifo_full();
        int blocked;
        do_reset();
        AR_addr_f[31:0] = 32'h0001_0000;
        AR_valid_f = 2'b01;
        AR_ready_f = 2'b10;
        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < 4 && AR_grant_f === 2'b00; i++) @(negedge clk);
            n_cmp++;
            if (AR_grant_f !== 2'b01) begin $display("FAIL full_ar%0d: got=%b want=01", k, AR_grant_f); n_err++; end
            @(negedge clk);
        end
        n_cmp++;
        if (cnt1 !== 3'd4) begin $display("FAIL full_cnt: got=%0d want=4", cnt1); n_err++; end
        blocked = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (AR_grant_f !== 2'b00) blocked++;
        end
        n_cmp++;
        if (blocked != 0) begin $display("FAIL full_blocked: grant_cycles=%0d want=0", blocked); n_err++; end
        R_valid_f = 2'b10; R_last_f = 2'b10; R_ready_f = 2'b01;
        for (int i = 0; i < 4 && R_grant_s_f === 2'b00; i++) @(negedge clk);
        n_cmp++;
        if (R_grant_m_f !== 2'b01) begin $display("FAIL full_r_grant_m: got=%b want=01", R_grant_m_f); n_err++; end
        @(negedge clk);
        R_valid_f = '0; R_last_f = '0;
        for (int i = 0; i < M && AR_grant_f === 2'b00; i++) @(negedge clk);
        n_cmp++;
        if (AR_grant_f !== 2'b01) begin $display("FAIL full_ar_resume: got=%b want=01", AR_grant_f); n_err++; end
        @(negedge clk);
        AR_valid_f = 2'b00;
        n_cmp++;
        if (cnt1 !== 3'd4) begin $display("FAIL full_refill: cnt1=%0d want=4", cnt1); n_err++; end
    endtask

    task automatic test_orphan();
        do_reset();
        R_valid_f = 2'b01;
        @(negedge clk);
        n_cmp += 3;
        if (R_err !== 1'b1)        begin $display("FAIL orphan_pulse: got=%b want=1", R_err); n_err++; end
        if (R_grant_s_f !== 2'b00) begin $display("FAIL orphan_grant_s: got=%b want=00", R_grant_s_f); n_err++; end
        if (R_grant_m_f !== 2'b00) begin $display("FAIL orphan_grant_m: got=%b want=00", R_grant_m_f); n_err++; end
        @(negedge clk);
        R_valid_f = 2'b00;
        n_cmp++;
        if (R_err !== 1'b0) begin $display("FAIL orphan_ptr_adv: got=%b want=0", R_err); n_err++; end
        @(negedge clk);
        n_cmp++;
        if (R_err !== 1'b0) begin $display("FAIL orphan_after: got=%b want=0", R_err); n_err++; end
    endtask

    task automatic test_backpressure();
        do_reset();
        issue_ar(0, 32'h0001_0000);
        R_valid_f = 2'b10; R_last_f = 2'b00; R_ready_f = 2'b01;
        for (int i = 0; i < 4 && R_grant_s_f === 2'b00; i++) @(negedge clk);
        n_cmp++;
        if (R_grant_s_f !== 2'b10) begin $display("FAIL bp_grant_s: got=%b want=10", R_grant_s_f); n_err++; end
        @(negedge clk);
        R_last_f = 2'b10; R_ready_f = 2'b00;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_cmp += 3;
            if (R_grant_m_f !== 2'b01) begin $display("FAIL bp_hold%0d_grant_m: got=%b want=01", i, R_grant_m_f); n_err++; end
            if (R_grant_s_f !== 2'b10) begin $display("FAIL bp_hold%0d_grant_s: got=%b want=10", i, R_grant_s_f); n_err++; end
            if (cnt1 !== 3'd1)         begin $display("FAIL bp_hold%0d_cnt: got=%0d want=1", i, cnt1); n_err++; end
        end
        R_ready_f = 2'b01;
        @(negedge clk);
        R_valid_f = '0; R_last_f = '0;
        n_cmp += 2;
        if (R_grant_m_f !== 2'b00) begin $display("FAIL bp_done_grant_m: got=%b want=00", R_grant_m_f); n_err++; end
        if (cnt1 !== 3'd0)         begin $display("FAIL bp_done_cnt: got=%0d want=0", cnt1); n_err++; end
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        issue_ar(1, 32'h0001_0000);
        issue_ar(0, 32'h0000_0000);
        R_valid_f = 2'b10; R_last_f = 2'b00; R_ready_f = 2'b10;
        for (int i = 0; i < 4 && R_grant_s_f === 2'b00; i++) @(negedge clk);
        n_cmp += 2;
        if (R_grant_m_f !== 2'b10) begin $display("FAIL mid_grant_m: got=%b want=10", R_grant_m_f); n_err++; end
        if (R_sel_m_f !== 2'b10)   begin $display("FAIL mid_sel_m: got=%b want=10", R_sel_m_f); n_err++; end
        #2 clr = 1'b0;
        #1;
        n_cmp += 4;
        if (R_grant_s_f !== 2'b00) begin $display("FAIL mid_rst_grant_s: got=%b want=00", R_grant_s_f); n_err++; end
        if (R_grant_m_f !== 2'b00) begin $display("FAIL mid_rst_grant_m: got=%b want=00", R_grant_m_f); n_err++; end
        if (R_sel_m_f !== 2'b00)   begin $display("FAIL mid_rst_sel_m: got=%b want=00", R_sel_m_f); n_err++; end
        if (AR_grant_f !== 2'b00)  begin $display("FAIL mid_rst_ar_grant: got=%b want=00", AR_grant_f); n_err++; end
        @(negedge clk);
        R_valid_f = '0;
        clr = 1'b1;
        n_cmp += 2;
        if (cnt0 !== 3'd0) begin $display("FAIL mid_cnt0: got=%0d want=0", cnt0); n_err++; end
        if (cnt1 !== 3'd0) begin $display("FAIL mid_cnt1: got=%0d want=0", cnt1); n_err++; end
        @(negedge clk);
        n_cmp++;
        if (R_grant_s_f !== 2'b00) begin $display("FAIL mid_post_grant_s: got=%b want=00", R_grant_s_f); n_err++; end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
        test_single();
        test_contention();
        test_fifo_full();
        test_orphan();
        test_backpressure();
        test_reset_mid_burst();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
